// File: rtl/fv_mul_sched_if.sv
// Handshake bundle between fv_mul_sched and its pk/u sources, the shared multiplier and
// the tagged result sink. master = the scheduler, slave = everything around it.
interface fv_mul_sched_if #(
    parameter int unsigned QW = 64,
    parameter int unsigned UW = 1
);
    logic          start;
    logic          busy;
    logic          done;
    logic          err;

    logic [QW-1:0] pk0_data;
    logic          pk0_vld;
    logic          pk0_rdy;
    logic [QW-1:0] pk1_data;
    logic          pk1_vld;
    logic          pk1_rdy;
    logic [UW-1:0] u_data;
    logic          u_vld;
    logic          u_rdy;

    logic [QW-1:0] m_p_data;
    logic          m_p_vld;
    logic          m_p_last;
    logic [UW-1:0] m_u_data;
    logic          m_u_vld;
    logic          m_u_last;
    logic          m_rdy;
    logic [QW-1:0] m_z_data;
    logic          m_z_vld;
    logic          m_z_last;

    logic [QW-1:0] o_data;
    logic          o_vld;
    logic          o_last;
    logic          o_sel;

    modport master (
        input  start,
        output busy, done, err,
        input  pk0_data, pk0_vld, output pk0_rdy,
        input  pk1_data, pk1_vld, output pk1_rdy,
        input  u_data, u_vld, output u_rdy,
        output m_p_data, m_p_vld, m_p_last,
        output m_u_data, m_u_vld, m_u_last,
        input  m_rdy,
        input  m_z_data, m_z_vld, m_z_last,
        output o_data, o_vld, o_last, o_sel
    );

    modport slave (
        output start,
        input  busy, done, err,
        output pk0_data, pk0_vld, input pk0_rdy,
        output pk1_data, pk1_vld, input pk1_rdy,
        output u_data, u_vld, input u_rdy,
        input  m_p_data, m_p_vld, m_p_last,
        input  m_u_data, m_u_vld, m_u_last,
        output m_rdy,
        output m_z_data, m_z_vld, m_z_last,
        input  o_data, o_vld, o_last, o_sel
    );
endinterface

// File: rtl/fv_mul_sched.sv
// Runs pk0*u then pk1*u through one shared multiplier; u is captured during the first
// feed and replayed from a local buffer for the second. Results are re-tagged and registered.
module fv_mul_sched #(
    parameter int unsigned N  = 16,
    parameter int unsigned QW = 64,
    parameter int unsigned UW = 1
) (
    input logic            clk,
    input logic            s_rst_n,
    fv_mul_sched_if.master bus
);
    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] CntLast = CW'(N - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StFeed0 = 3'd1;
    localparam logic [2:0] StWait0 = 3'd2;
    localparam logic [2:0] StFeed1 = 3'd3;
    localparam logic [2:0] StWait1 = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [UW-1:0] ubuf_q [N];

    logic [QW-1:0] o_data_q;
    logic          o_vld_q, o_last_q, o_sel_q, done_q, err_q;

    logic in_feed0, in_feed1, in_wait0, in_wait1, in_wait;
    logic cnt_last, beat, z_end, z_take;

    assign in_feed0 = (state_q == StFeed0);
    assign in_feed1 = (state_q == StFeed1);
    assign in_wait0 = (state_q == StWait0);
    assign in_wait1 = (state_q == StWait1);
    assign in_wait  = in_wait0 | in_wait1;
    assign cnt_last = (cnt_q == CntLast);
    assign z_end    = bus.m_z_vld & bus.m_z_last;
    assign z_take   = in_wait & bus.m_z_vld;

    // Feed-side forwarding depends only on state, counter and source streams, never on m_z_*.
    always_comb begin
        bus.pk0_rdy  = 1'b0;
        bus.pk1_rdy  = 1'b0;
        bus.u_rdy    = 1'b0;
        bus.m_p_vld  = 1'b0;
        bus.m_u_vld  = 1'b0;
        beat         = 1'b0;
        bus.m_p_data = in_feed1 ? bus.pk1_data : bus.pk0_data;
        bus.m_u_data = in_feed1 ? ubuf_q[cnt_q] : bus.u_data;
        bus.m_p_last = (in_feed0 | in_feed1) & cnt_last;
        bus.m_u_last = (in_feed0 | in_feed1) & cnt_last;
        if (in_feed0) begin
            bus.m_p_vld = bus.pk0_vld & bus.u_vld;
            bus.m_u_vld = bus.pk0_vld & bus.u_vld;
            beat        = bus.m_rdy & bus.pk0_vld & bus.u_vld;
            bus.pk0_rdy = beat;
            bus.u_rdy   = beat;
        end else if (in_feed1) begin
            bus.m_p_vld = bus.pk1_vld;
            bus.m_u_vld = bus.pk1_vld;
            beat        = bus.m_rdy & bus.pk1_vld;
            bus.pk1_rdy = beat;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StFeed0;
                    cnt_d   = '0;
                end
            end
            StFeed0: begin
                if (beat) begin
                    cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
                    if (cnt_last) state_d = StWait0;
                end
            end
            StWait0: begin
                if (z_end) state_d = StFeed1;
            end
            StFeed1: begin
                if (beat) begin
                    cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
                    if (cnt_last) state_d = StWait1;
                end
            end
            StWait1: begin
                if (z_end) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            o_data_q <= '0;
            o_vld_q  <= 1'b0;
            o_last_q <= 1'b0;
            o_sel_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            o_vld_q  <= z_take;
            o_last_q <= z_take & bus.m_z_last;
            done_q   <= in_wait1 & z_end;
            // A result while not waiting for one means the multiplier is out of step.
            err_q    <= err_q | (bus.m_z_vld & ~in_wait);
            if (z_take) begin
                o_data_q <= bus.m_z_data;
                o_sel_q  <= in_wait1;
            end
        end
    end

    // Replay buffer carries no reset; it is fully rewritten in every FEED0.
    always_ff @(posedge clk) begin
        if (in_feed0 && beat) begin
            ubuf_q[cnt_q] <= bus.u_data;
        end
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.o_data = o_data_q;
    assign bus.o_vld  = o_vld_q;
    assign bus.o_last = o_last_q;
    assign bus.o_sel  = o_sel_q;
endmodule
